// File: rtl/uart_tx_mmio.sv
`timescale 1ns/1ps
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV register window,
// byte FIFO and a registered TXD driven by a four-state frame FSM.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        CS,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        TXD,
  output logic        IRQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [15:0]     baud_q, baud_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [15:0]     div_q, div_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem [DEPTH];

  logic       hit, push_req, push, pop, full, empty, busy, bit_end;
  logic [1:0] offset;
  logic [4:0] count_ext;
  logic       unused_bits;

  assign hit       = CS && (ADDR[31:4] == BASE_ADDR[31:4]);
  assign offset    = ADDR[3:2];
  assign push_req  = hit && WE && (offset == 2'd0);
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != StIdle);
  // Acceptance looks only at the pre-edge count; a same-edge pop does not make room.
  assign push      = push_req && !full;
  assign bit_end   = (baud_q == 16'd0);
  assign count_ext = 5'(count_q);
  assign unused_bits = ^{ADDR[1:0], Data_BUS_WRITE[31:16]};

  // Register file and FIFO bookkeeping.
  always_comb begin
    ovf_d    = ovf_q;
    div_d    = div_q;
    rdata_d  = 32'd0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (hit && WE && (offset == 2'd1) && Data_BUS_WRITE[3]) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;
    if (hit && WE && (offset == 2'd2)) div_d = Data_BUS_WRITE[15:0];
    if (hit && !WE) begin
      unique case (offset)
        2'd1:    rdata_d = {19'd0, count_ext, 4'd0, ovf_q, busy, empty, full};
        2'd2:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame FSM; a bit ends on the cycle the baud counter reads zero.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = div_q;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          baud_d  = div_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = div_q;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            baud_d  = div_q;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // TXD follows the next state so the line register changes with the state.
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      bit_q    <= 3'd0;
      baud_q   <= 16'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      div_q    <= DEFAULT_DIV;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= Data_BUS_WRITE[7:0];
  end

  assign Data_BUS_READ = rdata_q;
  assign TXD           = txd_q;
  assign IRQ           = empty && !busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
// Bench for uart_tx_mmio: register vectors from a table, plus a per-cycle
// {TXD, IRQ} scoreboard queue filled when frames are launched.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        CS = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] Data_BUS_WRITE = 32'd0;
  logic [31:0] Data_BUS_READ;
  logic        TXD;
  logic        IRQ;

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .DEPTH      (8),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .CS            (CS),
    .WE            (WE),
    .ADDR          (ADDR),
    .Data_BUS_WRITE(Data_BUS_WRITE),
    .Data_BUS_READ (Data_BUS_READ),
    .TXD           (TXD),
    .IRQ           (IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic cs, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input string name);
    vec_t v;
    v.cs = cs; v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.name = name;
    vecs.push_back(v);
  endtask

  // One bus access sampled at the next rising edge; returns on the following falling edge.
  task automatic bus_cycle(input logic cs, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    CS = cs; WE = we; ADDR = addr; Data_BUS_WRITE = wdata;
    @(negedge CLK);
    CS = 1'b0; WE = 1'b0; ADDR = 32'd0; Data_BUS_WRITE = 32'd0;
  endtask

  task automatic exp_push(input logic txd, input logic irq, input int n);
    repeat (n) exp_q.push_back({txd, irq});
  endtask

  task automatic exp_frame(input logic [7:0] b, input int div);
    exp_push(1'b0, 1'b0, div + 1);
    for (int i = 0; i < 8; i++) exp_push(b[i], 1'b0, div + 1);
    exp_push(1'b1, 1'b0, div + 1);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d expected cycles left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Each queue entry is the expected line state just after one rising edge.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("txd_stream", 32'(TXD), 32'(mon_e[1]));
      check("irq_stream", 32'(IRQ), 32'(mon_e[0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  logic [7:0] b2b [9];

  initial begin
    add_vec(1'b1, 1'b0, A_ST,          32'd0,         32'h0000_0002, "status_reset");
    add_vec(1'b1, 1'b0, A_DIV,         32'd0,         32'd433,       "div_reset");
    add_vec(1'b1, 1'b1, A_DIV,         32'hABCD_1234, 32'd0,         "div_write");
    add_vec(1'b1, 1'b0, A_DIV,         32'd0,         32'h0000_1234, "div_readback");
    add_vec(1'b0, 1'b0, A_DIV,         32'd0,         32'd0,         "cs_low_read");
    add_vec(1'b1, 1'b0, A_TX,          32'd0,         32'd0,         "txdata_read");
    add_vec(1'b1, 1'b1, A_RSV,         32'hFFFF_FFFF, 32'd0,         "rsv_write");
    add_vec(1'b1, 1'b0, A_RSV,         32'd0,         32'd0,         "rsv_read");
    add_vec(1'b0, 1'b1, A_TX,          32'h5A,        32'd0,         "cs_low_push");
    add_vec(1'b1, 1'b1, BASE + 32'd16, 32'h5A,        32'd0,         "miss_push");
    add_vec(1'b0, 1'b1, A_DIV,         32'h7,         32'd0,         "cs_low_div");
    add_vec(1'b1, 1'b0, A_DIV,         32'd0,         32'h0000_1234, "div_kept");
    add_vec(1'b1, 1'b0, BASE + 32'd24, 32'd0,         32'd0,         "miss_read");
    add_vec(1'b1, 1'b0, A_ST,          32'd0,         32'h0000_0002, "status_still_empty");

    // Power-on reset: outputs settle without any clock edge.
    #1 Reset = 1'b0;
    #1;
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd1);
    check("rst_rdata", Data_BUS_READ, 32'd0);
    repeat (3) @(negedge CLK);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      bus_cycle(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check(vecs[i].name, Data_BUS_READ, vecs[i].rdata);
      check({vecs[i].name, "_txd"}, 32'(TXD), 32'd1);
    end

    // Single frame 0xA5 at 4 cycles per bit.
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd3);
    exp_push(1'b1, 1'b0, 1);
    exp_frame(8'hA5, 3);
    exp_push(1'b1, 1'b1, 2);
    bus_cycle(1'b1, 1'b1, A_TX, 32'hA5);
    repeat (4) @(negedge CLK);
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("status_busy", Data_BUS_READ, 32'h0000_0006);
    drain("single_frame");
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("status_after_frame", Data_BUS_READ, 32'h0000_0002);

    // Back-to-back frames at 1 cycle per bit; nine bytes also wrap the pointers.
    b2b = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'h01, 8'h80, 8'hC3, 8'h7E};
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd0);
    exp_push(1'b1, 1'b0, 1);
    for (int i = 0; i < 9; i++) exp_frame(b2b[i], 0);
    exp_push(1'b1, 1'b1, 2);
    for (int i = 0; i < 9; i++) bus_cycle(1'b1, 1'b1, A_TX, {24'd0, b2b[i]});
    drain("back_to_back");

    // Overflow: ten consecutive pushes, the tenth is dropped.
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd100);
    exp_push(1'b1, 1'b0, 1);
    for (int i = 1; i <= 9; i++) exp_frame(8'(i), 100);
    exp_push(1'b1, 1'b1, 2);
    for (int i = 1; i <= 10; i++) bus_cycle(1'b1, 1'b1, A_TX, 32'(i));
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    // FULL, OVF, count 8, and BUSY because the first byte is on the line.
    check("status_overflow", Data_BUS_READ, 32'h0000_080D);
    bus_cycle(1'b1, 1'b1, A_ST, 32'h0000_0007);
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("ovf_kept", Data_BUS_READ, 32'h0000_080D);
    bus_cycle(1'b1, 1'b1, A_ST, 32'h0000_0008);
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("ovf_cleared", Data_BUS_READ, 32'h0000_0805);
    drain("overflow_frames");

    // Divisor change during data bit 2 applies from bit 3 onward.
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd3);
    exp_push(1'b1, 1'b0, 1);
    exp_push(1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) exp_push(i[0] == 1'b0, 1'b0, 4);
    for (int i = 3; i < 8; i++) exp_push(i[0] == 1'b0, 1'b0, 8);
    exp_push(1'b1, 1'b0, 8);
    exp_push(1'b1, 1'b1, 2);
    bus_cycle(1'b1, 1'b1, A_TX, 32'h55);
    repeat (13) @(negedge CLK);
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd7);
    drain("mid_frame_div");

    // Asynchronous reset in the middle of a start bit.
    bus_cycle(1'b1, 1'b1, A_DIV, 32'd50);
    bus_cycle(1'b1, 1'b1, A_TX, 32'h00);
    repeat (20) @(negedge CLK);
    check("start_bit_low", 32'(TXD), 32'd0);
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("status_mid_frame", Data_BUS_READ, 32'h0000_0006);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_txd", 32'(TXD), 32'd1);
    check("async_rst_irq", 32'(IRQ), 32'd1);
    check("async_rst_rdata", Data_BUS_READ, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    bus_cycle(1'b1, 1'b0, A_ST, 32'd0);
    check("status_post_reset", Data_BUS_READ, 32'h0000_0002);
    bus_cycle(1'b1, 1'b0, A_DIV, 32'd0);
    check("div_post_reset", Data_BUS_READ, 32'd433);
    repeat (5) @(negedge CLK);
    check("idle_txd_post_reset", 32'(TXD), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
